wb_rr_interconnect: RTL and testbench
=====================================

Name: wb_rr_interconnect

Overview:
Parametrised Wishbone shared-bus interconnect connecting N_MASTERS initiators to N_SLAVES targets. It is the successor to the fixed 2x6 SoC fabric, used for core instruction/data masters plus future DMA or debug masters. It adds round-robin arbitration with bus locking while CYC is held, mask/base address decode, an error response for unmapped addresses, and a per-transfer timeout.

Parameters:
N_MASTERS, 2, number of masters (1..8)
N_SLAVES, 6, number of slaves (1..16)
AW, 32, address width
DW, 32, data width (multiple of 8)
SLAVE_BASE, {0x8000_0000,0x4000_0000,0x3000_0000,0x2000_0000,0x1000_0000,0x0000_0000}, packed N_SLAVES*AW base addresses, slave 0 in LSBs
SLAVE_MASK, all 0xF000_0000, packed N_SLAVES*AW decode masks
TIMEOUT, 255, cycles of STB without ACK/ERR before forced ERR; 0 disables

Ports:
i_clk  in  1  clock
i_rstn  in  1  asynchronous active-low reset
i_m_cyc  in  N_MASTERS  per-master CYC
i_m_stb  in  N_MASTERS  per-master STB
i_m_we  in  N_MASTERS  per-master WE
i_m_adr  in  N_MASTERS*AW  per-master address, master 0 in LSBs
i_m_dat  in  N_MASTERS*DW  per-master write data
i_m_sel  in  N_MASTERS*DW/8  per-master byte select
o_m_ack  out  N_MASTERS  ACK to each master
o_m_err  out  N_MASTERS  ERR to each master
o_m_dat  out  N_MASTERS*DW  read data to each master
o_s_cyc  out  N_SLAVES  per-slave CYC
o_s_stb  out  N_SLAVES  per-slave STB
o_s_we  out  1  shared WE
o_s_adr  out  AW  shared address
o_s_dat  out  DW  shared write data
o_s_sel  out  DW/8  shared byte select
i_s_ack  in  N_SLAVES  per-slave ACK
i_s_err  in  N_SLAVES  per-slave ERR
i_s_dat  in  N_SLAVES*DW  per-slave read data
o_grant  out  N_MASTERS  one-hot current grant (registered)
o_busy  out  1  high in BUSY/ERR states

Behaviour:
- Reset: state IDLE; o_grant=0; last_grant pointer = N_MASTERS-1, so master 0 wins first; timeout counter = 0. All o_m_ack/o_m_err/o_s_cyc/o_s_stb = 0; o_m_dat, o_s_adr, o_s_dat, o_s_sel, o_s_we = 0.
- IDLE: if any i_m_cyc is high, grant the first requester searching upward (with wrap) from last_grant+1. Register o_grant and go to BUSY. Grant latency is one cycle from CYC high.
- BUSY: the granted master's adr/dat/sel/we drive the shared slave bus. Decode is combinational on the granted address: a slave hits when (adr & MASK)==BASE; the lowest index wins on multiple hits. o_s_cyc[hit]=granted cyc and o_s_stb[hit]=granted stb; all other slaves see 0.
- Response routing: i_s_ack[hit]/i_s_err[hit]/i_s_dat[hit] pass combinationally to the granted master only, with zero added latency. Non-granted masters see ack=err=0 and dat=0.
- Lock: the grant is held while the granted i_m_cyc stays high, including multiple STB phases (RMW/burst).
- Release: the granted i_m_cyc falls, so o_s_cyc drops combinationally the same cycle. Next cycle: state IDLE, last_grant = granted index, o_grant=0. There is no same-cycle re-grant; the minimum gap between owners is 1 idle cycle.
- Unmapped: in BUSY with stb high and no hit, no slave is selected. Go to ERR; o_m_err[granted] pulses for exactly 1 cycle on the next cycle, then the state returns to BUSY. If stb is still high after the pulse, the sequence repeats.
- Timeout: the counter increments each BUSY cycle with granted stb high and no ack/err. It clears on ack, err, stb low, or leaving BUSY. When count==TIMEOUT-1, the next cycle forces o_m_err[granted]=1 for 1 cycle and deasserts o_s_cyc/o_s_stb for that cycle. A slave ACK arriving in that same cycle is suppressed. The counter saturates safely at TIMEOUT.
- A slave asserting ack and err together forwards both.
- Async reset mid-transfer forces all outputs to reset values immediately; no response is delivered.

Decomposition:
- package.vh: add default base/mask constants and an unmapped-region code. Existing WB macros remain for adapters.
- Sub-module rr_arbiter (N parameter): request vector, last_grant, enable -> one-hot grant, index. Reusable for a future crossbar.

Test Plan:
- Single master 0 reads 0x3000_0004; uart slave acks after 2 cycles with 0xA5A5_0001 -> o_s_cyc=6'b001000, o_m_ack[0] high 1 cycle with o_m_dat=0xA5A5_0001.
- Masters 0 and 1 assert cyc in the same cycle after reset, 4 back-to-back transfers each -> grants alternate 0,1,0,1,..., each with one idle cycle between owners.
- Master 1 holds cyc across 3 stb phases while master 0 requests -> o_grant stays 2'b10 until master 1 drops cyc, then 2'b01.
- Write to 0x5000_0000 (unmapped) -> no o_s_cyc bit set, o_m_err pulse 1 cycle on the following cycle.
- Slave 5 never acks with TIMEOUT=16 -> o_m_err after 16 stalled cycles; o_s_cyc[5] low during the err cycle.
- Deassert i_rstn mid-transfer -> all outputs 0 asynchronously; after release, master 0 is granted first.

Source files
------------

// File: rtl/wb_rr_interconnect_pkg.sv
// wb_rr_interconnect_pkg: shared types, default memory map and sizing helper for the
// round-robin Wishbone interconnect.
package wb_rr_interconnect_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_ERR} state_e;

    localparam int DEF_AW = 32;
    localparam int DEF_NS = 6;

    // Slave 0 sits in the LSBs: 0x0, 0x1, 0x2, 0x3 (uart), 0x4, 0x8 in the top nibble.
    localparam logic [DEF_NS*DEF_AW-1:0] DEF_SLAVE_BASE = {
        32'h8000_0000, 32'h4000_0000, 32'h3000_0000,
        32'h2000_0000, 32'h1000_0000, 32'h0000_0000
    };
    localparam logic [DEF_NS*DEF_AW-1:0] DEF_SLAVE_MASK = {DEF_NS{32'hF000_0000}};

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wb_rr_interconnect_rr_arbiter.sv
// rr_arbiter: round-robin pick of the first request at or after last_i+1 (with wrap);
// outputs both a one-hot grant and its index.
module rr_arbiter
    import wb_rr_interconnect_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [N-1:0]        req_i,
    input  logic [idx_w(N)-1:0] last_i,
    input  logic                en_i,
    output logic [N-1:0]        gnt_o,
    output logic [idx_w(N)-1:0] idx_o
);
    localparam int IW = idx_w(N);

    logic found;
    int   k;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(last_i) + i) % N;
            if (en_i && !found && req_i[k]) begin
                found    = 1'b1;
                gnt_o[k] = 1'b1;
                idx_o    = IW'(k);
            end
        end
    end

endmodule

// File: rtl/wb_rr_interconnect.sv
// wb_rr_interconnect: N-master / N-slave shared Wishbone bus with round-robin arbitration,
// CYC-held locking, mask/base decode, unmapped-address error and per-transfer timeout.
module wb_rr_interconnect
    import wb_rr_interconnect_pkg::*;
#(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 6,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_BASE = DEF_SLAVE_BASE,
    parameter logic [N_SLAVES*AW-1:0] SLAVE_MASK = DEF_SLAVE_MASK,
    parameter int TIMEOUT   = 255
) (
    input  logic                      i_clk,
    input  logic                      i_rstn,
    input  logic [N_MASTERS-1:0]      i_m_cyc,
    input  logic [N_MASTERS-1:0]      i_m_stb,
    input  logic [N_MASTERS-1:0]      i_m_we,
    input  logic [N_MASTERS*AW-1:0]   i_m_adr,
    input  logic [N_MASTERS*DW-1:0]   i_m_dat,
    input  logic [N_MASTERS*DW/8-1:0] i_m_sel,
    output logic [N_MASTERS-1:0]      o_m_ack,
    output logic [N_MASTERS-1:0]      o_m_err,
    output logic [N_MASTERS*DW-1:0]   o_m_dat,
    output logic [N_SLAVES-1:0]       o_s_cyc,
    output logic [N_SLAVES-1:0]       o_s_stb,
    output logic                      o_s_we,
    output logic [AW-1:0]             o_s_adr,
    output logic [DW-1:0]             o_s_dat,
    output logic [DW/8-1:0]           o_s_sel,
    input  logic [N_SLAVES-1:0]       i_s_ack,
    input  logic [N_SLAVES-1:0]       i_s_err,
    input  logic [N_SLAVES*DW-1:0]    i_s_dat,
    output logic [N_MASTERS-1:0]      o_grant,
    output logic                      o_busy
);
    localparam int MIW = idx_w(N_MASTERS);
    localparam int SIW = idx_w(N_SLAVES);
    localparam int CW  = idx_w(TIMEOUT + 1);
    localparam int SW  = DW / 8;

    state_e               state_q, state_d;
    logic [N_MASTERS-1:0] grant_q, grant_d, arb_gnt;
    logic [MIW-1:0]       gidx_q, gidx_d, last_q, last_d, arb_idx;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 g_cyc, g_stb, g_we, hit, s_ack, s_err;
    logic [AW-1:0]        g_adr;
    logic [DW-1:0]        g_dat, s_dat;
    logic [SW-1:0]        g_sel;
    logic [SIW-1:0]       hidx;

    rr_arbiter #(.N(N_MASTERS)) u_arb (
        .req_i  (i_m_cyc),
        .last_i (last_q),
        .en_i   (state_q == ST_IDLE),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    assign g_cyc = i_m_cyc[gidx_q];
    assign g_stb = i_m_stb[gidx_q];
    assign g_we  = i_m_we[gidx_q];
    assign g_adr = i_m_adr[gidx_q*AW +: AW];
    assign g_dat = i_m_dat[gidx_q*DW +: DW];
    assign g_sel = i_m_sel[gidx_q*SW +: SW];

    // Scanning downward lets the lowest matching slave overwrite higher ones.
    always_comb begin
        hit  = 1'b0;
        hidx = '0;
        for (int s = N_SLAVES - 1; s >= 0; s--) begin
            if ((g_adr & SLAVE_MASK[s*AW +: AW]) == SLAVE_BASE[s*AW +: AW]) begin
                hit  = 1'b1;
                hidx = SIW'(s);
            end
        end
    end

    assign s_ack = hit & i_s_ack[hidx];
    assign s_err = hit & i_s_err[hidx];
    assign s_dat = hit ? i_s_dat[hidx*DW +: DW] : '0;

    always_comb begin
        o_m_ack = '0;
        o_m_err = '0;
        o_m_dat = '0;
        o_s_cyc = '0;
        o_s_stb = '0;
        o_s_we  = 1'b0;
        o_s_adr = '0;
        o_s_dat = '0;
        o_s_sel = '0;
        o_busy  = (state_q != ST_IDLE);
        o_grant = grant_q;
        if (state_q == ST_BUSY) begin
            o_s_cyc[hidx]             = hit & g_cyc;
            o_s_stb[hidx]             = hit & g_stb;
            o_m_ack[gidx_q]           = s_ack;
            o_m_err[gidx_q]           = s_err;
            o_m_dat[gidx_q*DW +: DW]  = s_dat;
        end
        // The error cycle isolates all slaves, so a late ACK never reaches the master.
        if (state_q == ST_ERR)
            o_m_err[gidx_q] = 1'b1;
        if (o_busy) begin
            o_s_we  = g_we;
            o_s_adr = g_adr;
            o_s_dat = g_dat;
            o_s_sel = g_sel;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
        cnt_d   = '0;
        case (state_q)
            ST_IDLE: if (|i_m_cyc) begin
                state_d = ST_BUSY;
                grant_d = arb_gnt;
                gidx_d  = arb_idx;
            end
            ST_BUSY: if (!g_cyc) begin
                state_d = ST_IDLE;
                grant_d = '0;
                last_d  = gidx_q;
            end else if (g_stb && !hit) begin
                state_d = ST_ERR;
            end else if (g_stb && !s_ack && !s_err && TIMEOUT != 0) begin
                if (cnt_q == CW'(TIMEOUT - 1))
                    state_d = ST_ERR;
                else
                    cnt_d = cnt_q + CW'(cnt_q != CW'(TIMEOUT));
            end
            default: state_d = ST_BUSY;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            last_q  <= MIW'(N_MASTERS - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_wb_rr_interconnect.sv
// tb_wb_rr_interconnect: directed and randomized checks of the interconnect against a
// cycle-level owner/last/stall-count model derived from the bus rules.
module tb_wb_rr_interconnect;
    localparam int NM = 2, NS = 6, AW = 32, DW = 32, SW = DW / 8, TO = 16;
    localparam logic [NS*AW-1:0] BASES = {32'h8000_0000, 32'h4000_0000, 32'h3000_0000,
                                          32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [NS*AW-1:0] MASKS = {NS{32'hF000_0000}};

    logic clk = 1'b0;
    logic rstn;
    logic [NM-1:0] m_cyc, m_stb, m_we, m_ack, m_err, grant;
    logic [NM*AW-1:0] m_adr;
    logic [NM*DW-1:0] m_dat, m_rdat;
    logic [NM*SW-1:0] m_sel;
    logic [NS-1:0] s_cyc, s_stb, s_ack, s_err;
    logic [NS*DW-1:0] s_rdat;
    logic s_we, busy;
    logic [AW-1:0] s_adr;
    logic [DW-1:0] s_dat;
    logic [SW-1:0] s_sel;

    int passes = 0, fails = 0, checks = 0;
    int owner, last, cnt;
    bit err_now;
    logic [NM-1:0] seen_gnt, seen_ack, seen_err;
    logic [NS-1:0] seen_scyc, seen_sstb;
    logic [NM*DW-1:0] seen_mdat;

    wb_rr_interconnect #(
        .N_MASTERS(NM), .N_SLAVES(NS), .AW(AW), .DW(DW),
        .SLAVE_BASE(BASES), .SLAVE_MASK(MASKS), .TIMEOUT(TO)
    ) dut (
        .i_clk(clk), .i_rstn(rstn),
        .i_m_cyc(m_cyc), .i_m_stb(m_stb), .i_m_we(m_we), .i_m_adr(m_adr),
        .i_m_dat(m_dat), .i_m_sel(m_sel),
        .o_m_ack(m_ack), .o_m_err(m_err), .o_m_dat(m_rdat),
        .o_s_cyc(s_cyc), .o_s_stb(s_stb), .o_s_we(s_we), .o_s_adr(s_adr),
        .o_s_dat(s_dat), .o_s_sel(s_sel),
        .i_s_ack(s_ack), .i_s_err(s_err), .i_s_dat(s_rdat),
        .o_grant(grant), .o_busy(busy)
    );

    initial forever #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int decode(input logic [AW-1:0] a);
        logic [AW-1:0] b[NS], m[NS];
        for (int s = 0; s < NS; s++) begin
            b[s] = BASES[s*AW +: AW];
            m[s] = MASKS[s*AW +: AW];
        end
        for (int s = 0; s < NS; s++)
            if ((a & m[s]) == b[s]) return s;
        return -1;
    endfunction

    task automatic check_model();
        logic [NM-1:0] e_ack = '0, e_err = '0, e_gnt = '0;
        logic [NM*DW-1:0] e_mdat = '0;
        logic [NS-1:0] e_scyc = '0, e_sstb = '0;
        logic e_we = 1'b0;
        logic [AW-1:0] e_adr = '0;
        logic [DW-1:0] e_sdat = '0;
        logic [SW-1:0] e_sel = '0;
        int h;
        if (owner >= 0) begin
            e_gnt[owner] = 1'b1;
            e_we   = m_we[owner];
            e_adr  = m_adr[owner*AW +: AW];
            e_sdat = m_dat[owner*DW +: DW];
            e_sel  = m_sel[owner*SW +: SW];
            h = decode(e_adr);
            if (err_now) e_err[owner] = 1'b1;
            else if (h >= 0) begin
                e_scyc[h] = m_cyc[owner];
                e_sstb[h] = m_stb[owner];
                e_ack[owner] = s_ack[h];
                e_err[owner] = s_err[h];
                e_mdat[owner*DW +: DW] = s_rdat[h*DW +: DW];
            end
        end
        chk("grant", grant, e_gnt);
        chk("busy", busy, owner >= 0);
        chk("m_ack", m_ack, e_ack);
        chk("m_err", m_err, e_err);
        chk("m_dat", m_rdat, e_mdat);
        chk("s_cyc", s_cyc, e_scyc);
        chk("s_stb", s_stb, e_sstb);
        chk("s_we", s_we, e_we);
        chk("s_adr", s_adr, e_adr);
        chk("s_dat", s_dat, e_sdat);
        chk("s_sel", s_sel, e_sel);
    endtask

    task automatic model_next();
        int h, k;
        if (!rstn) begin
            owner = -1; last = NM - 1; cnt = 0; err_now = 0;
        end else if (owner < 0) begin
            for (int i = 1; i <= NM; i++) begin
                k = (last + i) % NM;
                if (m_cyc[k]) begin owner = k; break; end
            end
        end else if (err_now) begin
            err_now = 0;
        end else if (!m_cyc[owner]) begin
            last = owner; owner = -1; cnt = 0;
        end else begin
            h = decode(m_adr[owner*AW +: AW]);
            if (m_stb[owner] && h < 0) begin
                err_now = 1; cnt = 0;
            end else if (m_stb[owner] && h >= 0 && !s_ack[h] && !s_err[h]) begin
                cnt++;
                if (cnt == TO) begin err_now = 1; cnt = 0; end
            end else cnt = 0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        seen_gnt = grant; seen_ack = m_ack; seen_err = m_err;
        seen_scyc = s_cyc; seen_sstb = s_stb; seen_mdat = m_rdat;
        @(posedge clk);
        model_next();
        #1;
    endtask

    task automatic set_m(input int i, input bit cyc, input bit stb, input bit we, input logic [AW-1:0] a);
        m_cyc[i] = cyc; m_stb[i] = stb; m_we[i] = we;
        m_adr[i*AW +: AW] = a;
        m_dat[i*DW +: DW] = $urandom;
        m_sel[i*SW +: SW] = SW'($urandom);
    endtask

    initial begin
        int left[NM];
        int nxt, stalls;
        bit got;
        logic [NM-1:0] prev_g;
        rstn = 1'b0;
        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        s_ack = '0; s_err = '0; s_rdat = '0;
        owner = -1; last = NM - 1; cnt = 0; err_now = 0;
        repeat (2) step();
        chk("rst_grant", seen_gnt, 0);
        rstn = 1'b1;
        step();

        // Two masters contend from reset: grants must alternate starting at master 0.
        s_ack = '1;
        left[0] = 4; left[1] = 4; nxt = 0; prev_g = '0;
        set_m(0, 1, 1, 0, 32'h0000_0010);
        set_m(1, 1, 1, 1, 32'h1000_0020);
        for (int c = 0; c < 100 && (left[0] > 0 || left[1] > 0); c++) begin
            step();
            if (seen_gnt != 0 && prev_g == 0) begin
                chk("rr_order", seen_gnt, nxt == 0 ? 2'b01 : 2'b10);
                nxt ^= 1;
            end
            prev_g = seen_gnt;
            for (int i = 0; i < NM; i++) begin
                if (seen_ack[i]) begin left[i]--; m_cyc[i] = 1'b0; m_stb[i] = 1'b0; end
                else if (left[i] > 0) begin m_cyc[i] = 1'b1; m_stb[i] = 1'b1; end
            end
        end
        chk("rr_done", left[0] + left[1], 0);
        s_ack = '0; m_cyc = '0; m_stb = '0;
        repeat (2) step();

        // Master 0 reads the uart slave, which acks after two wait cycles.
        set_m(0, 1, 1, 0, 32'h3000_0004);
        step();
        step();
        chk("uart_scyc", seen_scyc, 6'b001000);
        step();
        s_ack[3] = 1'b1; s_rdat[3*DW +: DW] = 32'hA5A5_0001;
        step();
        chk("uart_ack", seen_ack, 2'b01);
        chk("uart_dat", seen_mdat[31:0], 32'hA5A5_0001);
        m_cyc = '0; m_stb = '0; s_ack = '0;
        repeat (2) step();

        // Master 1 locks the bus across three STB phases while master 0 waits.
        set_m(1, 1, 1, 0, 32'h2000_0000);
        step();
        set_m(0, 1, 1, 0, 32'h1000_0000);
        for (int p = 0; p < 6; p++) begin
            m_stb[1] = (p % 2 == 0);
            s_ack = (p % 2 == 0) ? '1 : '0;
            step();
            chk("lock_grant", seen_gnt, 2'b10);
        end
        m_cyc[1] = 1'b0; m_stb[1] = 1'b0; s_ack = '0;
        repeat (3) step();
        chk("lock_next", seen_gnt, 2'b01);
        m_cyc = '0; m_stb = '0;
        repeat (2) step();

        // Unmapped write: no slave selected, one-cycle error on the following cycle.
        set_m(0, 1, 1, 1, 32'h5000_0000);
        step();
        step();
        chk("unmap_scyc", seen_scyc, 0);
        step();
        chk("unmap_err", seen_err, 2'b01);
        m_cyc = '0; m_stb = '0;
        step();
        chk("unmap_pulse", seen_err, 0);
        step();

        // Slave 5 never answers: forced error after TO stalled cycles, slave isolated.
        set_m(0, 1, 1, 0, 32'h8000_0000);
        step();
        stalls = 0; got = 0;
        for (int c = 0; c < 40 && !got; c++) begin
            step();
            if (seen_err[0]) begin
                got = 1;
                chk("tmo_scyc", seen_scyc[5], 0);
            end else if (seen_sstb[5]) stalls++;
        end
        chk("tmo_seen", got, 1);
        chk("tmo_stalls", stalls, TO);
        m_cyc = '0; m_stb = '0;
        repeat (2) step();

        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NM; i++)
                set_m(i, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                      {4'($urandom_range(0, 15)), 28'($urandom)});
            s_ack = (c / 100) % 2 ? NS'($urandom) & NS'($urandom) & NS'($urandom) : NS'($urandom);
            s_err = NS'($urandom) & NS'($urandom) & NS'($urandom);
            for (int s = 0; s < NS; s++) s_rdat[s*DW +: DW] = $urandom;
            step();
        end
        m_cyc = '0; m_stb = '0; s_ack = '0; s_err = '0;
        repeat (2) step();

        // Asynchronous reset in the middle of a stalled transfer.
        set_m(0, 1, 1, 0, 32'h8000_0000);
        repeat (2) step();
        #2 rstn = 1'b0;
        #1;
        chk("arst_grant", grant, 0);
        chk("arst_busy", busy, 0);
        chk("arst_scyc", s_cyc, 0);
        chk("arst_sstb", s_stb, 0);
        chk("arst_mack", m_ack, 0);
        chk("arst_merr", m_err, 0);
        chk("arst_sadr", s_adr, 0);
        owner = -1; last = NM - 1; cnt = 0; err_now = 0;
        set_m(1, 1, 1, 0, 32'h4000_0000);
        step();
        rstn = 1'b1;
        repeat (2) step();
        chk("arst_first", seen_gnt, 2'b01);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
